// File: rtl/nn_layer_sequencer_if.sv
// Bus between the layer sequencer, the input activation RAM, the neuron layer
// datapath and the result consumer. The sequencer takes the master side.
interface nn_layer_sequencer_if #(
    parameter int unsigned NUM_NEURONS = 128,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned IDX_WIDTH   = 32
);
    logic                              start;
    logic                              src_ready;
    logic [IDX_WIDTH-1:0]              in_rd_addr;
    logic [DATA_WIDTH-1:0]             in_rd_data;
    logic                              layer_clear;
    logic [IDX_WIDTH-1:0]              local_addr;
    logic [DATA_WIDTH-1:0]             layer_data;
    logic                              layer_input_valid;
    logic [NUM_NEURONS-1:0]            out_valids;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] result_data;
    logic                              result_valid;
    logic                              result_ready;
    logic                              busy;
    logic                              error;

    modport master (
        input  start, src_ready, in_rd_data, out_valids, layer_out, result_ready,
        output in_rd_addr, layer_clear, local_addr, layer_data, layer_input_valid,
               result_data, result_valid, busy, error
    );

    modport slave (
        output start, src_ready, in_rd_data, out_valids, layer_out, result_ready,
        input  in_rd_addr, layer_clear, local_addr, layer_data, layer_input_valid,
               result_data, result_valid, busy, error
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Runs one fully-connected layer per start pulse: clear, stream activations, capture
// neuron outputs, hand off the result vector. Define LAYER_SEQ_TIMEOUT_EN for the WAIT_OUT watchdog.
module nn_layer_sequencer #(
    parameter int unsigned NUM_INPUTS     = 784,
    parameter int unsigned NUM_NEURONS    = 128,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned IDX_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                 clk,
    input logic                 rst,
    nn_layer_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_WAIT_OUT, S_RESULT
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

    state_t                            r_state, w_next;
    logic [IDX_WIDTH-1:0]              r_idx;
    logic [IDX_WIDTH-1:0]              r_addr;
    logic                              r_liv;
    logic [NUM_NEURONS-1:0]            r_captured;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] r_result;
    logic                              w_issue;
    logic                              w_cap_en;
    logic [NUM_NEURONS-1:0]            w_new_cap;
    logic                              w_all_done;
    logic                              w_timeout;

    assign w_issue    = (r_state == S_STREAM) && bus.src_ready;
    assign w_cap_en   = (r_state == S_STREAM) || (r_state == S_DRAIN) || (r_state == S_WAIT_OUT);
    assign w_new_cap  = w_cap_en ? (bus.out_valids & ~r_captured) : '0;
    assign w_all_done = &(r_captured | w_new_cap);

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_error;

    assign w_timeout = (r_state == S_WAIT_OUT) && !w_all_done &&
                       (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside WAIT_OUT, so every entry starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt  <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state != S_WAIT_OUT)
                r_tcnt <= '0;
            else if (!w_all_done)
                r_tcnt <= r_tcnt + TW'(1);
            if (r_state == S_CLEAR)
                r_error <= 1'b0;
            else if (w_timeout)
                r_error <= 1'b1;
        end
    end

    assign bus.error = r_error;
`else
    assign w_timeout = 1'b0;
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_next = S_CLEAR;
            S_CLEAR:    w_next = S_STREAM;
            S_STREAM:   if (w_issue && (r_idx == LAST_IDX)) w_next = S_DRAIN;
            S_DRAIN:    w_next = S_WAIT_OUT;
            S_WAIT_OUT: if (w_all_done || w_timeout) w_next = S_RESULT;
            S_RESULT:   if (bus.result_ready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_addr     <= '0;
            r_liv      <= 1'b0;
            r_captured <= '0;
            r_result   <= '0;
        end else begin
            r_liv <= w_issue;
            if (r_state == S_CLEAR) begin
                r_idx      <= '0;
                r_captured <= '0;
                r_result   <= '0;
            end else begin
                if (w_issue) begin
                    r_addr <= r_idx;
                    r_idx  <= r_idx + IDX_WIDTH'(1);
                end
                r_captured <= r_captured | w_new_cap;
                for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                    if (w_new_cap[i])
                        r_result[i*DATA_WIDTH +: DATA_WIDTH] <= bus.layer_out[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // The read address is presented in the issuing cycle so data and the
    // registered issue flag line up one cycle later; otherwise it holds.
    assign bus.in_rd_addr        = w_issue ? r_idx : r_addr;
    assign bus.local_addr        = bus.in_rd_addr;
    assign bus.layer_data        = bus.in_rd_data;
    assign bus.layer_input_valid = r_liv;
    assign bus.layer_clear       = (r_state == S_CLEAR);
    assign bus.result_data       = r_result;
    assign bus.result_valid      = (r_state == S_RESULT);
    assign bus.busy              = (r_state != S_IDLE);
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: stimulus pushes expected activations and
// result vectors; a negedge monitor pops and compares them.
module tb_nn_layer_sequencer;
    localparam int unsigned NI = 4;
    localparam int unsigned NN = 2;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 32;
    localparam int unsigned TO = 8;

    typedef struct {
        logic [NN*DW-1:0] data;
        logic             err;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_layer_sequencer_if #(.NUM_NEURONS(NN), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) u_if ();

    nn_layer_sequencer #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW),
        .IDX_WIDTH(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.master)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b1;
    logic [DW-1:0] ram [NI];
    logic [DW-1:0] q_stream [$];
    res_t        q_res [$];
    int          vcyc [$];
    int          dly [NN];
    int          rdly [NN];
    logic [DW-1:0] val [NN];
    logic [DW-1:0] rval [NN];

    always @(posedge clk) cyc <= cyc + 1;

    // Input RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (u_if.in_rd_addr < NI)
            u_if.in_rd_data <= ram[u_if.in_rd_addr];
        else
            u_if.in_rd_data <= 16'hDEAD;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (u_if.layer_input_valid) begin
                vcyc.push_back(cyc);
                if (q_stream.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL stream_extra: got data %0h expected no valid", u_if.layer_data);
                end else begin
                    logic [DW-1:0] e;
                    e = q_stream.pop_front();
                    check("stream_data", u_if.layer_data, e);
                end
            end
            if (u_if.result_valid) begin
                if (q_res.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL result_extra: got %0h expected no result", u_if.result_data);
                end else begin
                    check("result_data", u_if.result_data, q_res[0].data);
                    check("result_error", u_if.error, q_res[0].err);
                    if (u_if.result_ready) void'(q_res.pop_front());
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, u_if.busy, 0);
        check({tag, "_result_valid"}, u_if.result_valid, 0);
        check({tag, "_liv"}, u_if.layer_input_valid, 0);
        check({tag, "_clear"}, u_if.layer_clear, 0);
        check({tag, "_rd_addr"}, u_if.in_rd_addr, 0);
        check({tag, "_local_addr"}, u_if.local_addr, 0);
        check({tag, "_error"}, u_if.error, 0);
        check({tag, "_result_data"}, u_if.result_data, 0);
    endtask

    // Expected result: each lane keeps the value of its first pulse; lanes never pulsed read 0 and flag error.
    task automatic run(input int stall_mode, input int ready_mode, input int exp_done_k);
        res_t r;
        int   maxd;
        int   s;
        int   first_k;
        int   res_cyc;
        bit   done;
        bit   did_start;
        bit   rr;
        int   offs [NI];
        r.data = '0;
        r.err  = 1'b0;
        maxd   = 0;
        for (int i = 0; i < NN; i++) begin
            int fd;
            logic [DW-1:0] fv;
            fd = 0;
            fv = '0;
            if (dly[i] != 0) begin fd = dly[i]; fv = val[i]; end
            if (rdly[i] != 0 && (fd == 0 || rdly[i] < fd)) begin fd = rdly[i]; fv = rval[i]; end
            if (fd == 0) r.err = 1'b1;
            r.data[i*DW +: DW] = fv;
            if (fd > maxd) maxd = fd;
        end
        q_res.push_back(r);
        for (int i = 0; i < NI; i++) q_stream.push_back(ram[i]);
        vcyc.delete();

        @(posedge clk); #1;
        u_if.start = 1'b1;
        u_if.src_ready = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        s = cyc;
        check("layer_clear", u_if.layer_clear, 1);
        check("busy_run", u_if.busy, 1);

        done = 1'b0;
        did_start = 1'b0;
        first_k = -1;
        res_cyc = 0;
        for (int k = 1; k < 300 && !done; k++) begin
            logic [NN-1:0]    ov;
            logic [NN*DW-1:0] lo;
            @(posedge clk); #1;
            case (stall_mode)
                1:       u_if.src_ready = !(k >= 3 && k <= 5);
                2:       u_if.src_ready = ($urandom % 3) != 0;
                default: u_if.src_ready = 1'b1;
            endcase
            ov = '0;
            lo = '0;
            for (int i = 0; i < NN; i++) begin
                if (dly[i] == k) begin ov[i] = 1'b1; lo[i*DW +: DW] = val[i]; end
                if (rdly[i] == k) begin ov[i] = 1'b1; lo[i*DW +: DW] = rval[i]; end
            end
            u_if.out_valids = ov;
            u_if.layer_out = lo;
            if (u_if.result_valid && first_k < 0) begin
                first_k = k;
                check("result_after_last_lane", k > maxd, 1);
                if (exp_done_k > 0) check("result_latency", k, exp_done_k);
            end
            case (ready_mode)
                1:       rr = ($urandom % 4) == 0;
                2:       rr = u_if.result_valid && res_cyc >= 5;
                default: rr = 1'b1;
            endcase
            if (u_if.result_valid) res_cyc++;
            u_if.result_ready = rr;
            if (u_if.result_valid && !rr && !did_start) begin
                u_if.start = 1'b1;
                did_start = 1'b1;
            end else begin
                u_if.start = 1'b0;
            end
            @(negedge clk);
            if (u_if.result_valid && u_if.result_ready) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_timeout: got no result handshake expected one within bound");
        end
        @(posedge clk); #1;
        u_if.result_ready = 1'b0;
        u_if.start = 1'b0;
        u_if.out_valids = '0;
        check("idle_after_xfer_busy", u_if.busy, 0);
        check("idle_after_xfer_valid", u_if.result_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("start_ignored_busy", u_if.busy, 0);
        check("stream_drained", q_stream.size(), 0);
        check("result_drained", q_res.size(), 0);
        if (stall_mode != 2) begin
            for (int i = 0; i < NI; i++) offs[i] = 2 + i;
            if (stall_mode == 1) begin offs[2] = 7; offs[3] = 8; end
            check("valid_count", vcyc.size(), NI);
            for (int i = 0; i < NI && i < vcyc.size(); i++)
                check("valid_cycle", vcyc[i] - s, offs[i]);
        end
    endtask

    task automatic rand_setup();
        for (int i = 0; i < NI; i++) ram[i] = DW'($urandom);
        for (int i = 0; i < NN; i++) begin
            dly[i]  = $urandom_range(1, NI + 5);
            val[i]  = DW'($urandom);
            rdly[i] = ($urandom % 2) ? dly[i] + $urandom_range(1, 3) : 0;
            rval[i] = DW'($urandom);
        end
    endtask

    initial begin
        u_if.start = 1'b0;
        u_if.src_ready = 1'b0;
        u_if.out_valids = '0;
        u_if.layer_out = '0;
        u_if.result_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        ram[0] = 16'h0010; ram[1] = 16'h0020; ram[2] = 16'h0030; ram[3] = 16'h0040;
        dly[0] = 6; val[0] = 16'hABCD; rdly[0] = 0; rval[0] = '0;
        dly[1] = 6; val[1] = 16'h1234; rdly[1] = 0; rval[1] = '0;
        run(0, 0, 0);

        rand_setup();
        run(1, 0, 0);

        rand_setup();
        dly[0] = 6; val[0] = 16'h0005; rdly[0] = 8; rval[0] = 16'h7777;
        dly[1] = 8; val[1] = 16'hFFFB; rdly[1] = 0;
        run(0, 0, 0);

        rand_setup();
        run(0, 2, 0);

        rand_setup();
        mon_en = 1'b0;
        @(posedge clk); #1;
        u_if.start = 1'b1;
        u_if.src_ready = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midrun_reset");
        rst = 1'b0;
        q_stream.delete();
        q_res.delete();
        mon_en = 1'b1;
        rand_setup();
        run(0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            rand_setup();
            run(2, 1, 0);
        end

`ifdef LAYER_SEQ_TIMEOUT_EN
        rand_setup();
        dly[0] = 6; val[0] = 16'h0042; rdly[0] = 0;
        dly[1] = 0; rdly[1] = 0;
        run(0, 0, int'(NI + 2 + TO));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Sequences one fully-connected layer per `start` pulse.
- Clears the neuron accumulators, then streams NUM_INPUTS activations from an external input RAM into the layer. The same index drives the layer's weight-memory `local_addr`.
- Captures each neuron's result as its `out_valid` asserts, then presents the full output vector on a valid/ready handshake.
- Sits between the previous layer's activation buffer and the layer datapath (neuron array plus per-neuron weight/bias memories).

Parameters:
- NUM_INPUTS, 784, activations per input vector.
- NUM_NEURONS, 128, neurons in the layer; width of `out_valids`.
- DATA_WIDTH, 16, activation and neuron output width.
- IDX_WIDTH, 32, width of `local_addr` and `in_rd_addr`.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_OUT; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run the layer; honoured only in IDLE.
- src_ready  in  1  input RAM may be read this cycle; low stalls streaming.
- in_rd_addr  out  IDX_WIDTH  input RAM read address; RAM data returns 1 cycle later.
- in_rd_data  in  DATA_WIDTH  input RAM read data.
- layer_clear  out  1  one-cycle pulse; OR-ed with rst into the neuron array.
- local_addr  out  IDX_WIDTH  weight-memory address; always equals in_rd_addr.
- layer_data  out  DATA_WIDTH  activation to the layer; combinational pass-through of in_rd_data.
- layer_input_valid  out  1  layer_data and the weight outputs are aligned and valid.
- out_valids  in  NUM_NEURONS  per-neuron completion flags from the layer.
- layer_out  in  NUM_NEURONS*DATA_WIDTH  packed neuron outputs; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- result_data  out  NUM_NEURONS*DATA_WIDTH  captured output vector.
- result_valid  out  1  result_data is held stable.
- result_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.
- error  out  1  result completed by timeout; valid while result_valid is high.

Behaviour:
- Reset (synchronous, rst=1): state=IDLE. The following all clear to 0: idx, in_rd_addr, local_addr, layer_input_valid, layer_clear, captured mask, result_data, result_valid, busy, error. Reset mid-run aborts immediately with no result.
- IDLE:
  - start=1 → CLEAR.
  - start while busy is ignored; it is not queued.
- CLEAR (1 cycle):
  - layer_clear=1, idx=0, captured mask=0, result_data=0, error=0.
  - → STREAM.
- STREAM (each cycle):
  - If src_ready=1: issue in_rd_addr=local_addr=idx, set issue flag, idx++.
  - If src_ready=0: no issue; addresses hold their last value.
  - layer_input_valid is the issue flag registered 1 cycle. This aligns it with in_rd_data and the registered weight-memory output.
  - Exactly NUM_INPUTS issues in ascending order 0..NUM_INPUTS-1. There are no gaps or duplicates; stalls only insert bubbles.
  - On issuing index NUM_INPUTS-1 → DRAIN.
- DRAIN (1 cycle): layer_input_valid=1 for the last element; no new issue. → WAIT_OUT.
- WAIT_OUT:
  - For each lane i with out_valids[i]=1 and captured[i]=0: result_data lane i ← layer_out lane i, captured[i] ← 1.
  - Later pulses on an already-captured lane are ignored.
  - Capture is also enabled in STREAM/DRAIN; early out_valids are captured, not lost.
  - When all bits are set (including bits set this cycle) → RESULT.
- RESULT:
  - result_valid=1; result_data and error held stable.
  - Transfer completes on the cycle result_valid & result_ready. Next cycle: result_valid=0, → IDLE.
  - start during RESULT is ignored.
- Latency: with src_ready held 1, the first layer_input_valid is 2 cycles after start, and the last is NUM_INPUTS+1 cycles after start.
- idx arithmetic: unsigned, compared to NUM_INPUTS-1; it never wraps during a run.
- out_valids activity in IDLE or CLEAR is ignored.

Optional Feature:
- Macro: LAYER_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_OUT, reset on entry.
  - On reaching TIMEOUT_CYCLES with lanes uncaptured: → RESULT with error=1. Uncaptured lanes read 0.
  - A normal completion gives error=0.
- Undefined: WAIT_OUT waits indefinitely; error is constant 0 and no counter logic exists.

Test Plan (NUM_INPUTS=4, NUM_NEURONS=2, DATA_WIDTH=16 unless noted):
- Basic run: start with src_ready=1; RAM holds 0x0010,0x0020,0x0030,0x0040 → in_rd_addr 0,1,2,3 on consecutive cycles; layer_input_valid high for 4 cycles starting 2 cycles after start, with matching data. Model out_valids=2'b11 with layer_out={0x1234,0xABCD} → result_data={0x1234,0xABCD}, result_valid=1, error=0.
- Stall: src_ready low for 3 cycles after idx 1 is issued → layer_input_valid gap of exactly 3 cycles; the sequence is still 0,1,2,3 with no duplicates.
- Staggered completion: lane 0 valid (0x0005), then lane 1 valid 2 cycles later (0xFFFB), with lane 0 re-pulsed carrying 0x7777 → result_data={0xFFFB,0x0005}; RESULT entered only after lane 1.
- Backpressure: result_ready=0 for 5 cycles → result_valid stays 1 and result_data is stable. A start pulse during this time is ignored. result_ready=1 → IDLE the next cycle; busy=0.
- Reset mid-run: assert rst while idx=2 → next cycle all outputs are 0 and state is IDLE. A new start then runs cleanly from idx 0 and layer_clear pulses.
- Timeout (LAYER_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8): only lane 0 completes (0x0042) → after 8 WAIT_OUT cycles, result_valid=1, error=1, result_data={0x0000,0x0042}.
